// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-master initiator: valid/ready commands in, pipelined NONSEQ transfers out.
// Optional data-phase stall watchdog on hang_irq when AHB_MST_TIMEOUT_EN is defined.
module ahb_lite_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    output logic        hang_irq
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? 2'd2 : sz;
    endfunction

    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] r;
        case (sz)
            2'd0:    r = a;
            2'd1:    r = {a[31:1], 1'b0};
            default: r = {a[31:2], 2'b00};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] r;
        case (sz)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] rd, input logic [1:0] lo,
                                                 input logic [1:0] sz);
        logic [31:0] r;
        case (sz)
            2'd0: begin
                case (lo)
                    2'd0:    r = {24'h000000, rd[7:0]};
                    2'd1:    r = {24'h000000, rd[15:8]};
                    2'd2:    r = {24'h000000, rd[23:16]};
                    default: r = {24'h000000, rd[31:24]};
                endcase
            end
            2'd1:    r = lo[1] ? {16'h0000, rd[31:16]} : {16'h0000, rd[15:0]};
            default: r = rd;
        endcase
        return r;
    endfunction

    logic        a_full_r;
    logic [31:0] a_addr_r;
    logic        a_write_r;
    logic [1:0]  a_size_r;
    logic [31:0] a_wdata_r;
    logic        d_full_r;
    logic        d_write_r;
    logic [1:0]  d_size_r;
    logic [1:0]  d_lo_r;
    logic [31:0] hwdata_r;
    logic        err_hold_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic err_mask_s;
    logic addr_go_s;
    logic data_go_s;
    logic cmd_ready_s;
    logic cmd_fire_s;

    // The mask covers both ERROR cycles so the queued address phase is withdrawn from the bus.
    assign err_mask_s  = (d_full_r & HRESP & ~HREADY) | err_hold_r;
    assign addr_go_s   = a_full_r & ~err_mask_s & HREADY;
    assign data_go_s   = d_full_r & HREADY;
    assign cmd_ready_s = ~a_full_r | (HREADY & ~err_mask_s);
    assign cmd_fire_s  = cmd_valid & cmd_ready_s;

    assign cmd_ready = cmd_ready_s;
    assign HTRANS    = (a_full_r & ~err_mask_s) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = a_addr_r;
    assign HWRITE    = a_write_r;
    assign HSIZE     = {1'b0, a_size_r};
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HWDATA    = hwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Address-phase register: refills from the command port, empties when its phase completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_full_r  <= 1'b0;
            a_addr_r  <= 32'h00000000;
            a_write_r <= 1'b0;
            a_size_r  <= 2'd0;
            a_wdata_r <= 32'h00000000;
        end else if (cmd_fire_s) begin
            a_full_r  <= 1'b1;
            a_addr_r  <= align_addr(cmd_addr, norm_size(cmd_size));
            a_write_r <= cmd_write;
            a_size_r  <= norm_size(cmd_size);
            a_wdata_r <= cmd_wdata;
        end else if (addr_go_s) begin
            a_full_r <= 1'b0;
        end
    end

    // Data-phase register plus the one-cycle ERROR hold flop.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_full_r   <= 1'b0;
            d_write_r  <= 1'b0;
            d_size_r   <= 2'd0;
            d_lo_r     <= 2'd0;
            hwdata_r   <= 32'h00000000;
            err_hold_r <= 1'b0;
        end else begin
            err_hold_r <= d_full_r & HRESP & ~HREADY;
            if (addr_go_s) begin
                d_full_r  <= 1'b1;
                d_write_r <= a_write_r;
                d_size_r  <= a_size_r;
                d_lo_r    <= a_addr_r[1:0];
                hwdata_r  <= lane_replicate(a_wdata_r, a_size_r);
            end else if (data_go_s) begin
                d_full_r <= 1'b0;
            end
        end
    end

    // Response pulse registered on the edge that completes the data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h00000000;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= data_go_s;
            rsp_err_r   <= data_go_s & HRESP;
            rsp_rdata_r <= (data_go_s & ~d_write_r) ? lane_extract(HRDATA, d_lo_r, d_size_r)
                                                    : 32'h00000000;
        end
    end

`ifdef AHB_MST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] stall_cnt_r;
    logic [CW-1:0] stall_cnt_s;
    logic          hang_irq_r;

    // Consecutive stalled data-phase cycles, saturating at the limit.
    always_comb begin
        stall_cnt_s = stall_cnt_r;
        if (HREADY) begin
            stall_cnt_s = '0;
        end else if (d_full_r && (stall_cnt_r != LIMIT)) begin
            stall_cnt_s = stall_cnt_r + 1'b1;
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
    end

    // Watchdog flag follows the saturated count and drops when the stall ends.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_cnt_r <= '0;
            hang_irq_r  <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_s;
            hang_irq_r  <= ~HREADY & (stall_cnt_s == LIMIT);
        end
    end

    assign hang_irq = hang_irq_r;
`else
    assign hang_irq = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Randomized and directed bench for ahb_lite_cmd_master with a transaction-level reference model.
module tb_ahb_lite_cmd_master;

    localparam int TO = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  cmd_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP, hang_irq;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahb_lite_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .hang_irq(hang_irq)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_rec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // command source
    cmd_t c;
    bit   c_valid = 1'b0;
    bit   accepted;
    int   acc_cyc;
    int   n_acc;

    // reference model
    cmd_t        q_a[$];
    cmd_t        m_d;
    bit          m_d_act = 1'b0;
    bit          m_rsp_v = 1'b0;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_err;
    bit          m_err2 = 1'b0;
    int          low_cnt = 0;

    // slave behaviour
    bit          s_err2nd = 1'b0;
    logic [1:0]  force_q[$];   // {HREADY, HRESP} applied on data-phase cycles
    bit          rand_slave = 1'b0;
    int          rd_mode = 0;  // 0 random, 1 addr+0x100, 2 fixed
    logic [31:0] rd_fixed = 32'h0;

    rsp_rec_t    rsp_log[$];
    logic [31:0] last_hwdata, last_haddr;
    logic [2:0]  last_hsize;
    int          hang_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd3) ? 4 : (1 << s);
    endfunction

    function automatic logic [31:0] exp_addr(input cmd_t x);
        return x.addr - (x.addr % nbytes(x.size));
    endfunction

    function automatic logic [31:0] exp_wdata(input cmd_t x);
        logic [63:0] unit, r;
        int nb;
        nb = nbytes(x.size);
        unit = {32'h0, x.wdata} & ((64'd1 << (8 * nb)) - 64'd1);
        r = 64'd0;
        for (int i = 0; i < 4; i += nb) r = r | (unit << (8 * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] rd, input cmd_t x);
        logic [63:0] v;
        int nb;
        nb = nbytes(x.size);
        v = {32'h0, rd} >> (8 * (exp_addr(x) % 4));
        v = v & ((64'd1 << (8 * nb)) - 64'd1);
        return v[31:0];
    endfunction

    function automatic rsp_rec_t log_at(input int i);
        rsp_rec_t r;
        r.err = 1'bx; r.rdata = 32'hxxxxxxxx; r.cyc = -100;
        if (i < rsp_log.size()) r = rsp_log[i];
        return r;
    endfunction

    // Compare every output against the model, then advance the model over the coming edge.
    task automatic check_update();
        bit err_now, exp_rdy, fire, a_go, d_go, exp_hang;
        rsp_rec_t rec;
        err_now = (m_d_act && HRESP && !HREADY) || m_err2;
        exp_rdy = (q_a.size() == 0) || (HREADY && !err_now);
`ifdef AHB_MST_TIMEOUT_EN
        exp_hang = (low_cnt >= TO);
`else
        exp_hang = 1'b0;
`endif
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
        chk("htrans", 32'(HTRANS), (q_a.size() != 0 && !err_now) ? 32'd2 : 32'd0);
        chk("hburst", 32'(HBURST), 32'd0);
        chk("hprot", 32'(HPROT), 32'd3);
        chk("hang_irq", 32'(hang_irq), 32'(exp_hang));
        if (hang_irq === 1'b1) hang_seen++;
        if (q_a.size() != 0) begin
            chk("haddr", HADDR, exp_addr(q_a[0]));
            chk("hwrite", 32'(HWRITE), 32'(q_a[0].write));
            chk("hsize", 32'(HSIZE), (q_a[0].size == 2'd3) ? 32'd2 : 32'(q_a[0].size));
        end
        if (m_d_act && m_d.write) begin
            chk("hwdata", HWDATA, exp_wdata(m_d));
            last_hwdata = HWDATA;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        if (m_rsp_v) begin
            chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
            rec.err = rsp_err; rec.rdata = rsp_rdata; rec.cyc = cyc;
            rsp_log.push_back(rec);
        end
        fire = c_valid && exp_rdy;
        a_go = (q_a.size() != 0) && !err_now && HREADY;
        d_go = m_d_act && HREADY;
        m_rsp_v = d_go;
        if (d_go) begin
            m_rsp_err   = HRESP;
            m_rsp_rdata = m_d.write ? 32'h0 : exp_rdata(HRDATA, m_d);
        end
        if (HREADY) low_cnt = 0;
        else if (m_d_act && low_cnt < TO) low_cnt++;
        m_err2 = m_d_act && HRESP && !HREADY;
        if (a_go) begin
            last_haddr = HADDR;
            last_hsize = HSIZE;
            m_d = q_a.pop_front();
            m_d_act = 1'b1;
        end else if (d_go) begin
            m_d_act = 1'b0;
        end
        if (fire) begin
            q_a.push_back(c);
            accepted = 1'b1;
            acc_cyc = cyc;
            n_acc++;
            c_valid = 1'b0;
        end
    endtask

    task automatic tick();
        int r;
        @(negedge HCLK);
        cyc++;
        if (s_err2nd) begin
            HREADY = 1'b1; HRESP = 1'b1; s_err2nd = 1'b0;
        end else if (m_d_act && force_q.size() != 0) begin
            {HREADY, HRESP} = force_q.pop_front();
            if (!HREADY && HRESP) s_err2nd = 1'b1;
        end else if (m_d_act && rand_slave) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin HREADY = 1'b0; HRESP = 1'b0; end
            else if (r == 2) begin HREADY = 1'b0; HRESP = 1'b1; s_err2nd = 1'b1; end
            else begin HREADY = 1'b1; HRESP = 1'b0; end
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
        end
        case (rd_mode)
            1:       HRDATA = m_d.addr + 32'h100;
            2:       HRDATA = rd_fixed;
            default: HRDATA = $urandom();
        endcase
        cmd_valid = c_valid;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_size  = c.size;
        cmd_wdata = c.wdata;
        #1;
        check_update();
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d, output int n);
        c.write = w; c.addr = a; c.size = s; c.wdata = d;
        c_valid = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 50) begin
            tick();
            n++;
        end
        if (!accepted) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: command %h not accepted within %0d cycles", a, n);
            c_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || m_d_act || m_rsp_v || c_valid) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: pipeline still busy after %0d cycles", n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
        chk({tag, "_haddr"}, HADDR, 32'd0);
        chk({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
        chk({tag, "_hsize"}, 32'(HSIZE), 32'd0);
        chk({tag, "_hwdata"}, HWDATA, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_hang"}, 32'(hang_irq), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rsp_rec_t r;
        HRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 2'd0; cmd_wdata = 32'h0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        c.write = 1'b0; c.addr = 32'h0; c.size = 2'd0; c.wdata = 32'h0;
        m_d = c;
        #3;
        chk_reset_vals("por");
        repeat (2) @(posedge HCLK);
        #2 HRESETn = 1'b1;

        // 1: single zero-wait word write
        rsp_log.delete();
        send(1'b1, 32'h40000000, 2'd2, 32'h000000A5, n);
        drain();
        r = log_at(0);
        chk("t1_count", rsp_log.size(), 32'd1);
        chk("t1_err", 32'(r.err), 32'd0);
        chk("t1_rdata", r.rdata, 32'd0);
        chk("t1_hwdata", last_hwdata, 32'h000000A5);
        chk("t1_latency", r.cyc - acc_cyc, 32'd3);

        // 2: back-to-back word reads
        rsp_log.delete();
        rd_mode = 1;
        for (int i = 0; i < 4; i++) send(1'b0, 32'(i * 4), 2'd2, 32'h0, n);
        drain();
        chk("t2_count", rsp_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_rdata", log_at(i).rdata, 32'h100 + 32'(i * 4));
            if (i > 0) chk("t2_gap", log_at(i).cyc - log_at(i - 1).cyc, 32'd1);
        end

        // 3: byte read lane select and byte write replication
        rsp_log.delete();
        rd_mode = 2; rd_fixed = 32'hDEADBEEF;
        send(1'b0, 32'h00000013, 2'd0, 32'h0, n);
        drain();
        chk("t3_haddr", last_haddr, 32'h00000013);
        chk("t3_hsize", 32'(last_hsize), 32'd0);
        chk("t3_rdata", log_at(0).rdata, 32'h000000DE);
        send(1'b1, 32'h00000021, 2'd0, 32'h0000005A, n);
        drain();
        chk("t3_hwdata", last_hwdata, 32'h5A5A5A5A);

        // 4: three wait states with a second command queued
        rsp_log.delete();
        rd_mode = 0;
        repeat (3) force_q.push_back(2'b00);
        send(1'b1, 32'h00000100, 2'd2, 32'h12345678, n);
        send(1'b0, 32'h00000204, 2'd2, 32'h0, n);
        send(1'b0, 32'h00000308, 2'd1, 32'h0, n);
        chk("t4_third_accept_cycles", n, 32'd4);
        drain();
        chk("t4_count", rsp_log.size(), 32'd3);
        for (int i = 0; i < 3; i++) chk("t4_err", 32'(log_at(i).err), 32'd0);

        // 5: two-cycle ERROR on the first of two pipelined writes
        rsp_log.delete();
        force_q.push_back(2'b01);
        send(1'b1, 32'h00000400, 2'd2, 32'h00000011, n);
        send(1'b1, 32'h00000404, 2'd2, 32'h00000022, n);
        drain();
        chk("t5_count", rsp_log.size(), 32'd2);
        chk("t5_err_first", 32'(log_at(0).err), 32'd1);
        chk("t5_err_second", 32'(log_at(1).err), 32'd0);

        // 6: long stall (watchdog) then reset in the middle of a stall
        rsp_log.delete();
        hang_seen = 0;
        repeat (10) force_q.push_back(2'b00);
        send(1'b1, 32'h00000500, 2'd2, 32'hCAFEF00D, n);
        drain();
`ifdef AHB_MST_TIMEOUT_EN
        chk("t6_hang_cycles", hang_seen, 32'd3);
`else
        chk("t6_hang_cycles", hang_seen, 32'd0);
`endif
        rsp_log.delete();
        repeat (10) force_q.push_back(2'b00);
        send(1'b1, 32'h00000600, 2'd2, 32'h0BADBEEF, n);
        repeat (4) tick();
        #2 HRESETn = 1'b0;
        #1;
        chk_reset_vals("mid");
        q_a.delete(); force_q.delete();
        m_d_act = 1'b0; m_rsp_v = 1'b0; m_err2 = 1'b0; low_cnt = 0;
        s_err2nd = 1'b0; c_valid = 1'b0;
        @(posedge HCLK);
        #2 HRESETn = 1'b1;
        repeat (5) tick();
        chk("t6_no_rsp_after_reset", rsp_log.size(), 32'd0);

        // random commands against a random slave
        rsp_log.delete();
        rand_slave = 1'b1;
        rd_mode = 0;
        n_acc = 0;
        for (int i = 0; i < 400; i++) begin
            if (!c_valid && $urandom_range(0, 9) < 7) begin
                c.write = 1'($urandom_range(0, 1));
                c.addr  = $urandom();
                c.size  = 2'($urandom_range(0, 3));
                c.wdata = $urandom();
                c_valid = 1'b1;
            end
            tick();
        end
        c_valid = 1'b0;
        drain();
        chk("rand_rsp_count", rsp_log.size(), 32'(n_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
AHB-Lite single-master initiator. It converts a simple valid/ready command stream (read/write, address, size, data) into pipelined AHB-Lite NONSEQ transfers. It drives the shared slave bus that memory-mapped peripherals (LED, GPIO, timer) sit on, and handles wait states and the two-cycle ERROR response. Each completed transfer returns a one-cycle response pulse carrying read data and an error flag.

Parameters:
TIMEOUT_CYCLES, 1024, consecutive HREADY-low data-phase cycles before hang_irq asserts (used only with the optional feature)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  32  byte address
cmd_size  in  2  0=byte, 1=half, 2=word (3 is illegal and treated as word)
cmd_wdata  in  32  write data, right-justified
rsp_valid  out  1  one-cycle pulse: transfer completed
rsp_rdata  out  32  read data, zero-extended, right-justified (0 for writes)
rsp_err  out  1  transfer ended with ERROR response
HADDR  out  32  AHB address
HTRANS  out  2  IDLE(00) or NONSEQ(10) only
HWRITE  out  1  write strobe
HSIZE  out  3  {0, size}
HBURST  out  3  constant 000 (SINGLE)
HPROT  out  4  constant 0011
HWDATA  out  32  write data, lane-replicated
HREADY  in  1  bus ready
HRESP  in  1  0=OKAY, 1=ERROR
HRDATA  in  32  read data
hang_irq  out  1  stall indication (optional feature)

Behaviour:
- Reset: everything is asynchronous on HRESETn low.
  - Address-phase register (A) and data-phase register (D) are empty.
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, hang_irq=0.
- A register:
  - Holds {addr, write, size, wdata}.
  - Drives HADDR, HWRITE and HSIZE directly from flops.
  - HADDR low bits are masked to alignment: half clears bit0; word clears [1:0].
- HTRANS=NONSEQ when A is full and err_mask=0; otherwise IDLE.
- Address phase completes on HCLK edge with HREADY=1 and HTRANS=NONSEQ:
  - A moves to D.
  - A refills from cmd in the same edge if cmd_valid.
- cmd_ready = !A_full | (HREADY & !err_mask). This combinational path from HREADY is intentional.
- Data phase (D full):
  - HWDATA comes from D.
  - Byte size: byte replicated ×4. Half size: half replicated ×2. Word size: as-is.
  - The data phase completes on an edge with HREADY=1.
- Response, registered the cycle after data-phase completion:
  - rsp_valid=1 for one cycle.
  - rsp_err=HRESP.
  - For reads, rsp_rdata = HRDATA lane selected by D.addr[1:0] and size, then zero-extended.
  - For writes, rsp_rdata=0.
- Throughput: back-to-back commands give one transfer per cycle with zero wait states. First-command latency: cmd accept to rsp_valid = 3 edges (A, D, rsp).
- ERROR handling:
  - err_mask = D_full & HRESP & !HREADY, i.e. the first ERROR cycle.
  - err_mask is also held through the second ERROR cycle by a flop set on the first cycle.
  - While err_mask=1, HTRANS is forced IDLE and A is retained, not consumed, so the pipelined command is cancelled on the bus.
  - The retained A re-issues as NONSEQ on the cycle after the second ERROR cycle.
  - The errored transfer reports rsp_err=1. No automatic retry.
- HREADY low with D full: A and D both hold. Outputs are stable.
- HRESP=1 with HREADY=1 without a preceding HRESP=1/HREADY=0 cycle is a protocol violation. It is still recorded as rsp_err=1.
- Reset mid-transfer: the pipeline is flushed and no rsp is produced for in-flight commands.
- Commands are never reordered. Responses come in command order.

Optional Feature:
Macro: AHB_MST_TIMEOUT_EN
- With the macro defined:
  - A counter (width $clog2(TIMEOUT_CYCLES)+1) counts consecutive cycles with D full and HREADY=0.
  - When the count reaches TIMEOUT_CYCLES, hang_irq=1.
  - hang_irq stays high until the stalled data phase completes (HREADY=1); it clears on that edge.
  - The counter clears on any HREADY=1 cycle.
- Without the macro: no counter; hang_irq is tied to 0. The port list is identical.

Test Plan:
1. Write 0x40000000, word, data 0x000000A5, slave zero-wait -> NONSEQ one cycle, HWDATA=0x000000A5 next cycle, rsp_valid pulse with rsp_err=0, rsp_rdata=0.
2. Four back-to-back word reads 0x0,0x4,0x8,0xC, HRDATA=addr+0x100, no waits -> HTRANS NONSEQ four consecutive cycles, four consecutive rsp_valid pulses, rsp_rdata 0x100,0x104,0x108,0x10C in order.
3. Byte read addr 0x13, HRDATA=0xDEADBEEF -> HADDR=0x13, HSIZE=000, rsp_rdata=0x000000DE. Byte write 0x5A to 0x21 -> HWDATA=0x5A5A5A5A.
4. Slave inserts 3 wait states on a write with a second command queued -> HADDR of second command held stable for 4 cycles, accepted on the HREADY=1 edge, cmd_ready low during waits.
5. ERROR on first of two pipelined writes (HRESP=1/HREADY=0 then HRESP=1/HREADY=1) -> HTRANS=IDLE in both error cycles, rsp_err=1 for first, second command re-issued NONSEQ afterwards and completes with rsp_err=0.
6. With AHB_MST_TIMEOUT_EN and TIMEOUT_CYCLES=8, HREADY held low 10 cycles in data phase -> hang_irq rises after the 8th low cycle, falls on the HREADY=1 edge. Without the macro, hang_irq stays 0. Also assert HRESETn mid-stall -> all outputs at reset values, no rsp_valid.
